// File: rtl/lcd_ctrl_if.sv
// LCD datapath control bundle: refresh request in, select lines and bus strobes out.
interface lcd_ctrl_if;
    logic       refresh_req;
    logic [1:0] init_sel;
    logic [1:0] mux_sel;
    logic       data_sel;
    logic       DB_sel;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       ready;

    modport master (
        input  refresh_req,
        output init_sel, mux_sel, data_sel, DB_sel,
        output lcd_e, lcd_rs, lcd_rw, ready
    );

    modport slave (
        output refresh_req,
        input  init_sel, mux_sel, data_sel, DB_sel,
        input  lcd_e, lcd_rs, lcd_rw, ready
    );
endinterface

// File: rtl/lcd_ctrl.sv
// LCD sequencer: power-up init commands, then periodic address + 4-digit refresh.
module lcd_ctrl #(
    parameter int PWRUP_CYC    = 750000,
    parameter int E_PULSE_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int REFRESH_CYC  = 2500000,
    parameter int CNT_W        = 22
) (
    input  logic        clk,
    input  logic        reset,
    lcd_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE
    } state_t;

    localparam logic [CNT_W-1:0] PW_END  = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_END   = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_END = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_END = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] REF_END = CNT_W'(REFRESH_CYC - 1);

    state_t           state, state_n;
    logic [3:0]       step, step_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pending, pending_n;
    logic             rdy, rdy_n;
    logic [1:0]       isel, isel_n, msel, msel_n;
    logic             dsel, dsel_n, dbsel, dbsel_n, rs, rs_n, e;

    always_comb begin
        state_n   = state;
        step_n    = step;
        rdy_n     = rdy;
        pending_n = pending | (bus.refresh_req && state != IDLE);
        unique case (state)
            PWRUP: if (cnt == PW_END) begin
                state_n = SETUP;
                step_n  = 4'd0;
            end
            SETUP: state_n = PULSE;
            PULSE: if (cnt == E_END) state_n = HOLD;
            HOLD:  state_n = WAIT;
            WAIT: if (cnt == ((step == 4'd3) ? CLR_END : CMD_END)) begin
                if (step == 4'd3) rdy_n = 1'b1;
                if (step < 4'd8) begin
                    step_n  = step + 4'd1;
                    state_n = SETUP;
                end else if (pending || bus.refresh_req) begin
                    // queued request: skip IDLE entirely
                    step_n    = 4'd4;
                    state_n   = SETUP;
                    pending_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            IDLE: if (bus.refresh_req || cnt == REF_END) begin
                step_n  = 4'd4;
                state_n = SETUP;
            end
            default: state_n = PWRUP;
        endcase
        cnt_n = (state_n != state) ? '0 : cnt + 1'b1;
    end

    always_comb begin
        isel_n  = 2'd0;
        msel_n  = 2'd0;
        dsel_n  = 1'b0;
        dbsel_n = 1'b1;
        rs_n    = 1'b0;
        unique case (1'b1)
            (step_n < 4'd4):  isel_n = step_n[1:0];
            (step_n == 4'd4): dbsel_n = 1'b0;
            default: begin
                msel_n = 2'(4'd8 - step_n);
                dsel_n = 1'b1;
                rs_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PWRUP;
            step    <= 4'd0;
            cnt     <= '0;
            pending <= 1'b0;
            rdy     <= 1'b0;
            isel    <= 2'd0;
            msel    <= 2'd0;
            dsel    <= 1'b0;
            dbsel   <= 1'b1;
            rs      <= 1'b0;
            e       <= 1'b0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            cnt     <= cnt_n;
            pending <= pending_n;
            rdy     <= rdy_n;
            isel    <= isel_n;
            msel    <= msel_n;
            dsel    <= dsel_n;
            dbsel   <= dbsel_n;
            rs      <= rs_n;
            e       <= (state_n == PULSE);
        end
    end

    assign bus.init_sel = isel;
    assign bus.mux_sel  = msel;
    assign bus.data_sel = dsel;
    assign bus.DB_sel   = dbsel;
    assign bus.lcd_e    = e;
    assign bus.lcd_rs   = rs;
    assign bus.lcd_rw   = 1'b0;
    assign bus.ready    = rdy;
endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: models the datapath and predicts every E pulse time and payload.
module tb_lcd_ctrl;
    localparam int PW  = 5;
    localparam int EP  = 2;
    localparam int CMD = 3;
    localparam int CLR = 6;
    localparam int REF = 20;
    localparam logic [7:0] INIT_CMD [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    typedef struct packed {
        logic       rs;
        logic [1:0] isel;
        logic [1:0] msel;
        logic       ds;
        logic       dbs;
        logic [7:0] db;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    lcd_ctrl_if bus();

    lcd_ctrl #(
        .PWRUP_CYC(PW), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CMD),
        .CLR_WAIT_CYC(CLR), .REFRESH_CYC(REF), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [3:0] dig [4];
    logic [7:0] db;
    always_comb begin
        db = 8'hCC;
        if (bus.DB_sel)
            db = bus.data_sel ? 8'h30 + {4'h0, dig[bus.mux_sel]}
                              : INIT_CMD[bus.init_sel];
    end

    int    cyc = 0;
    int    stab_bad = 0;
    int    rise_tq [$];
    snap_t rise_sq [$];
    int    fall_tq [$];
    int    ready_tq [$];
    logic  e_prev = 1'b0, r_prev = 1'b0;
    snap_t prev_s = '0, rise_s = '0, cur;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        cur = {bus.lcd_rs, bus.init_sel, bus.mux_sel, bus.data_sel, bus.DB_sel, db};
        if (bus.lcd_e && !e_prev) begin
            rise_tq.push_back(cyc);
            rise_sq.push_back(cur);
            rise_s = cur;
            if (cur !== prev_s) stab_bad = stab_bad + 1;
        end else if (bus.lcd_e && cur !== rise_s) begin
            stab_bad = stab_bad + 1;
        end else if (!bus.lcd_e && e_prev && !reset) begin
            fall_tq.push_back(cyc);
            if (cur !== rise_s) stab_bad = stab_bad + 1;
        end
        if (bus.ready && !r_prev) ready_tq.push_back(cyc);
        e_prev = bus.lcd_e;
        r_prev = bus.ready;
        prev_s = cur;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // expected payload of write item s, with mask of the fields it defines
    function automatic void exp_write(input int s, output snap_t e, output snap_t m);
        e = '0;
        m = '0;
        m.rs  = 1'b1;
        m.dbs = 1'b1;
        m.db  = 8'hFF;
        if (s < 4) begin
            e.isel = 2'(s);  m.isel = 2'b11;
            m.ds   = 1'b1;   e.dbs  = 1'b1;
            e.db   = INIT_CMD[s];
        end else if (s == 4) begin
            e.db = 8'hCC;
        end else begin
            e.rs   = 1'b1;
            e.msel = 2'(8 - s); m.msel = 2'b11;
            e.ds   = 1'b1;      m.ds   = 1'b1;
            e.dbs  = 1'b1;
            e.db   = 8'h30 + {4'h0, dig[8 - s]};
        end
    endfunction

    function automatic int wlen(input int s);
        return 2 + EP + ((s == 3) ? CLR : CMD);
    endfunction

    task automatic tick_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_rises(input int n, input int budget);
        for (int i = 0; i < budget && rise_tq.size() < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_req;
        bus.refresh_req = 1'b1;
        @(posedge clk);
        #2;
        bus.refresh_req = 1'b0;
    endtask

    task automatic test_reset;
        bus.refresh_req = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_strobes: got e/rs/rw/rdy=%b want 0000",
                     {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.ready});
        end
        n_cmp++;
        if ({bus.init_sel, bus.mux_sel, bus.data_sel, bus.DB_sel} !== 6'b000001) begin
            n_bad++;
            $display("FAIL reset_sels: got %b want 000001",
                     {bus.init_sel, bus.mux_sel, bus.data_sel, bus.DB_sel});
        end
    endtask

    task automatic test_init(input string tag);
        int n0, f0, r0, base, t;
        snap_t e, m;
        dig = '{4'd1, 4'd2, 4'd3, 4'd4};
        @(posedge clk);
        #2;
        reset = 1'b0;
        base = cyc;
        n0 = rise_tq.size();
        f0 = fall_tq.size();
        r0 = ready_tq.size();
        wait_rises(n0 + 9, 400);
        n_cmp++;
        if (rise_tq.size() !== n0 + 9) begin
            n_bad++;
            $display("FAIL %s_pulses: got %0d want 9", tag, rise_tq.size() - n0);
        end
        t = base + PW + 1;
        for (int s = 0; s < 9; s++) begin
            if (n0 + s < rise_tq.size()) begin
                exp_write(s, e, m);
                n_cmp++;
                if (rise_tq[n0 + s] !== t) begin
                    n_bad++;
                    $display("FAIL %s_rise%0d: got cycle %0d want %0d",
                             tag, s, rise_tq[n0 + s] - base, t - base);
                end
                n_cmp++;
                if ((rise_sq[n0 + s] & m) !== e) begin
                    n_bad++;
                    $display("FAIL %s_item%0d: got %h want %h",
                             tag, s, rise_sq[n0 + s] & m, e);
                end
            end
            t += wlen(s);
        end
        if (rise_tq.size() > n0) tick_to(rise_tq[$] + EP + 1);
        n_cmp++;
        if (ready_tq.size() !== r0 + 1) begin
            n_bad++;
            $display("FAIL %s_ready_cnt: got %0d want 1", tag, ready_tq.size() - r0);
        end else begin
            t = base + PW + 1 + wlen(0) + wlen(1) + wlen(2) + wlen(3) - 1;
            n_cmp++;
            if (ready_tq[r0] !== t) begin
                n_bad++;
                $display("FAIL %s_ready_t: got %0d want %0d",
                         tag, ready_tq[r0] - base, t - base);
            end
        end
        for (int s = 0; s < 8; s++) begin
            if (f0 + s + 1 < fall_tq.size()) begin
                n_cmp++;
                if (fall_tq[f0 + s + 1] - fall_tq[f0 + s] !== wlen(s)) begin
                    n_bad++;
                    $display("FAIL %s_gap%0d: got %0d want %0d", tag, s,
                             fall_tq[f0 + s + 1] - fall_tq[f0 + s], wlen(s));
                end
            end
        end
    endtask

    task automatic test_auto_refresh;
        int n0, t;
        snap_t e, m;
        foreach (dig[i]) dig[i] = 4'($urandom_range(0, 9));
        n0 = rise_tq.size();
        t = fall_tq[$] + 2 + CMD + REF;
        wait_rises(n0 + 5, 200);
        n_cmp++;
        if (rise_tq.size() !== n0 + 5) begin
            n_bad++;
            $display("FAIL auto_pulses: got %0d want 5", rise_tq.size() - n0);
        end
        for (int s = 4; s < 9; s++) begin
            if (n0 + s - 4 < rise_tq.size()) begin
                exp_write(s, e, m);
                n_cmp++;
                if (rise_tq[n0 + s - 4] !== t || (rise_sq[n0 + s - 4] & m) !== e) begin
                    n_bad++;
                    $display("FAIL auto_item%0d: got t=%0d %h want t=%0d %h", s,
                             rise_tq[n0 + s - 4], rise_sq[n0 + s - 4] & m, t, e);
                end
            end
            t += wlen(s);
        end
        if (rise_tq.size() > n0) tick_to(rise_tq[$] + EP + 1);
    endtask

    task automatic test_refresh_req;
        int n0, k, idle0, t;
        snap_t e, m;
        for (int it = 0; it < 4; it++) begin
            k = (it == 0) ? 4 : int'($urandom_range(0, REF - 1));
            foreach (dig[i]) dig[i] = 4'($urandom_range(0, 9));
            idle0 = fall_tq[$] + 1 + CMD;
            n0 = rise_tq.size();
            tick_to(idle0 + k);
            pulse_req();
            wait_rises(n0 + 5, 200);
            n_cmp++;
            if (rise_tq.size() !== n0 + 5) begin
                n_bad++;
                $display("FAIL req%0d_pulses: got %0d want 5", it, rise_tq.size() - n0);
            end
            t = idle0 + k + 2;
            for (int s = 4; s < 9; s++) begin
                if (n0 + s - 4 < rise_tq.size()) begin
                    exp_write(s, e, m);
                    n_cmp++;
                    if (rise_tq[n0 + s - 4] !== t || (rise_sq[n0 + s - 4] & m) !== e) begin
                        n_bad++;
                        $display("FAIL req%0d_item%0d: got t=%0d %h want t=%0d %h", it, s,
                                 rise_tq[n0 + s - 4], rise_sq[n0 + s - 4] & m, t, e);
                    end
                end
                t += wlen(s);
            end
            if (rise_tq.size() > n0) tick_to(rise_tq[$] + EP + 1);
        end
    endtask

    task automatic test_back_to_back;
        int n0, r0, t;
        snap_t e, m;
        t = fall_tq[$] + 1 + CMD + 2;
        n0 = rise_tq.size();
        tick_to(fall_tq[$] + 1 + CMD);
        pulse_req();
        wait_rises(n0 + 1, 50);
        r0 = (rise_tq.size() > n0) ? rise_tq[n0] : cyc;
        n_cmp++;
        if (r0 !== t) begin
            n_bad++;
            $display("FAIL b2b_start: got %0d want %0d", r0, t);
        end
        tick_to(r0 + wlen(4) + wlen(5));
        pulse_req();
        @(posedge clk);
        #2;
        pulse_req();
        wait_rises(n0 + 11, 300);
        n_cmp++;
        if (rise_tq.size() !== n0 + 11) begin
            n_bad++;
            $display("FAIL b2b_pulses: got %0d want 11", rise_tq.size() - n0);
        end
        for (int j = 0; j < 11; j++) begin
            if (n0 + j < rise_tq.size()) begin
                exp_write(4 + j % 5, e, m);
                n_cmp++;
                if (rise_tq[n0 + j] !== t || (rise_sq[n0 + j] & m) !== e) begin
                    n_bad++;
                    $display("FAIL b2b_item%0d: got t=%0d %h want t=%0d %h", j,
                             rise_tq[n0 + j], rise_sq[n0 + j] & m, t, e);
                end
            end
            t += (j == 9) ? EP + 2 + CMD + REF : wlen(4 + j % 5);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        snap_t e, m;
        n0 = rise_tq.size();
        wait_rises(n0 + 2, 100);
        exp_write(6, e, m);
        n_cmp++;
        if (rise_tq.size() !== n0 + 2 || (rise_sq[$] & m) !== e) begin
            n_bad++;
            $display("FAIL mid_at_step6: got %0d pulses %h want 2 %h",
                     rise_tq.size() - n0, rise_sq[$] & m, e);
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        n_cmp++;
        if ({bus.lcd_e, bus.ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_reset: got e/rdy=%b want 00", {bus.lcd_e, bus.ready});
        end
    endtask

    initial begin
        bus.refresh_req = 1'b0;
        dig = '{4'd0, 4'd0, 4'd0, 4'd0};
        test_reset();
        test_init("init");
        test_auto_refresh();
        test_refresh_req();
        test_back_to_back();
        test_reset_mid();
        test_init("replay");
        n_cmp++;
        if (stab_bad !== 0) begin
            n_bad++;
            $display("FAIL setup_hold: got %0d unstable cycles want 0", stab_bad);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
